uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver for the `io_rx` pin of `top`, and the receiving end of the line that the UART transmitter drives on `io_tx`. It synchronises the asynchronous input and detects 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. Each received byte is presented on a valid/ready port to the core logic, and framing and overrun events are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 434, gives clock cycles per bit (50 MHz / 115200); legal range 4..65535.
- `clock`  in  1  is the single system clock; all state is on its rising edge.
- `reset`  in  1  is the reset: asynchronous, active-high; it clears all state immediately.
- `io_rx`  in  1  is the asynchronous serial input; it idles high.
- `rx_data`  out  8  is the received byte; it is stable while `rx_valid` is high.
- `rx_valid`  out  1  is high while a byte is held.
- `rx_ready`  in  1  is asserted by the consumer; a byte is taken on a cycle where `rx_valid & rx_ready`.
- `frame_error`  out  1  is a one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  is a one-cycle pulse when an unconsumed byte is overwritten.
- `busy`  out  1  is high whenever the FSM is not IDLE.

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_error`=0, `overrun`=0, `busy`=0, state=IDLE, and both synchroniser flops=1 (idle line).
- `io_rx` passes through a 2-flop synchroniser. All decisions use the synchronised signal `rxs`.
- IDLE: when `rxs`=0, load the bit counter with `CLKS_PER_BIT/2 - 1` (integer division) and go to START.
- START: count down to 0, then re-sample `rxs`.
  - If `rxs`=1, the start bit was a glitch: return to IDLE with no output.
  - If `rxs`=0, reload the counter with `CLKS_PER_BIT-1`, clear the bit index, and go to DATA.
- DATA: at each counter expiry, shift `rxs` into bit[index] (LSB first) and increment index. After index 7, reload the counter and go to STOP.
- STOP: at counter expiry, sample `rxs`.
  - If `rxs`=1: copy the shift register to `rx_data` and set `rx_valid`, then go to IDLE.
  - If `rxs`=0: pulse `frame_error`, discard the byte, leave `rx_valid`/`rx_data` untouched, and go to BREAK.
- BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering frames.
- Handshake:
  - `rx_valid` stays high until consumed, and `rx_data` does not change while it is high, except on overwrite.
  - On a consume cycle with no new byte, `rx_valid` clears on the next edge.
- New byte completes while `rx_valid`=1:
  - If `rx_ready`=0 in that cycle, the new byte overwrites `rx_data`, `rx_valid` stays 1, and `overrun` pulses.
  - If `rx_ready`=1 in that cycle, the old byte is consumed, the new byte is loaded, `rx_valid` stays 1, and there is no `overrun`.
- `rx_ready` is ignored while `rx_valid`=0.
- Reset mid-frame aborts the frame immediately and returns everything to reset values. The first frame after reset is detected on the next falling edge of `rxs`.

## Timing
- Synchroniser latency is 2 cycles from a pin edge to `rxs`.
- The start edge is seen in cycle T0 (first cycle with `rxs`=0 while IDLE).
- The start bit is validated at T0 + `CLKS_PER_BIT/2`. Data bit n is sampled at T0 + `CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT`, for n=0..7.
- The stop bit is sampled at T0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`. `rx_valid`, `frame_error` and `overrun` are registered and assert on the following edge.
- `busy` rises the cycle after T0 and falls the cycle after leaving STOP, or after leaving BREAK.
- Back-to-back frames are supported: IDLE is re-entered about `CLKS_PER_BIT/2` before the stop bit ends, which gives ±~5% baud tolerance.
- Counter width is `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits and does not wrap, because STOP is entered after index 7.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` {IDLE, START, DATA, STOP, BREAK};
  - `UART_DATA_BITS`=8;
  - a function `uart_clks_per_bit(clock_hz, baud)` for top-level parameterisation.
- Sub-module `bit_sync` is a 2-flop synchroniser with a reset value parameter (here 1) and the same clock/reset. It is reusable for other pins.

## Test plan
All scenarios use `CLKS_PER_BIT`=8, and the bench drives `io_rx` with an ideal UART model.

1. Reset pulse with `io_rx`=1 idle → all outputs 0; `busy` stays 0 for 100 cycles.
2. Send 0xA5 with `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0xA5 on the cycle after the stop sample (T0+77). Then pulse `rx_ready` for one cycle → `rx_valid`=0 on the next edge.
3. A 3-cycle low glitch on `io_rx` → returns to IDLE after the start check; no `rx_valid` and no `frame_error`.
4. Send 0x3C with the stop bit forced low, then hold the line low for 40 cycles → one `frame_error` pulse; `rx_valid` stays 0; `busy` stays high until the line returns high. A following 0x81 is received correctly.
5. Send 0x11 then 0x22 back-to-back with `rx_ready`=0 → one `overrun` pulse and `rx_data`=0x22. Repeat with `rx_ready`=1 held in the 0x22 completion cycle → no `overrun`, `rx_valid` stays 1, and `rx_data`=0x22.
6. Assert `reset` during data bit 4 of 0xFF → outputs return to reset values within the same cycle. Then send 0x5A → received as 0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// frame width and a helper to derive the bit period from clock and baud rate.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Rounded to the nearest whole clock so e.g. 50 MHz / 115200 gives 434.
    function automatic int unsigned uart_clks_per_bit(input int unsigned clock_hz,
                                                      input int unsigned baud);
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte port between the UART receiver (master) and the core
// logic that consumes received bytes (slave).
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input; the reset value lets
// the output start at the pin's idle level.
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised line, byte handed
// out on a valid/ready port with single-cycle framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = uart_clks_per_bit(50_000_000, 115_200)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_rx,
    uart_rx_if.master   rx,
    output logic        frame_error,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(UART_DATA_BITS - 1);

    logic rxs;

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      fe_q, fe_d;
    logic                      ovr_q, ovr_d;
    logic                      byte_done;
    logic                      stop_low;

    bit_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (io_rx),
        .q     (rxs)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    // The counter always counts down to zero; each state acts only on expiry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_low  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_FULL;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = CNT_FULL;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
                    byte_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stop_low = 1'b1;
                    state_d  = BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A completing byte wins over a consume in the same cycle, so valid stays set.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = stop_low;
        ovr_d   = 1'b0;
        if (byte_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~rx.rx_ready;
        end else if (valid_q && rx.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx.rx_data  = data_q;
    assign rx.rx_valid = valid_q;
    assign frame_error = fe_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule
